// File: rtl/sm_tc_conv_pipe_pkg.sv
// Shared types and width helpers for the sign-magnitude / two's-complement converter.
package sm_tc_pkg;

  typedef enum logic {
    MODE_SM2TC = 1'b0,
    MODE_TC2SM = 1'b1
  } conv_mode_e;

  function automatic int unsigned lane_w(input int unsigned mag_w);
    return mag_w + 32'd1;
  endfunction

  function automatic int unsigned bus_w(input int unsigned mag_w, input int unsigned lanes);
    return lanes * lane_w(mag_w);
  endfunction

endpackage

// File: rtl/sm_tc_conv_pipe_if.sv
// Valid/ready bundle between the converter and its producer/consumer.
interface sm_tc_conv_pipe_if
  import sm_tc_pkg::*;
#(
  parameter int unsigned MAG_W = 13,
  parameter int unsigned LANES = 4
);
  localparam int unsigned DW = bus_w(MAG_W, LANES);

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_nz;
  logic [LANES-1:0] out_ovf;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_nz, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_nz, out_ovf
  );
endinterface

// File: rtl/sm_tc_conv_pipe_lane.sv
// Combinational single-lane converter; direction chosen by mode_i.
module sm_tc_lane
  import sm_tc_pkg::*;
#(
  parameter int unsigned MAG_W = 13
) (
  input  conv_mode_e     mode_i,
  input  logic [MAG_W:0] word_i,
  output logic [MAG_W:0] word_o,
  output logic           nz_o,
  output logic           ovf_o
);
  localparam logic [MAG_W:0] ONE = {{MAG_W{1'b0}}, 1'b1};

  logic [MAG_W:0] mag_s;
  logic [MAG_W:0] neg_s;

  // Per-lane conversion; the most negative TC value has no SM image and saturates.
  always_comb begin
    word_o = '0;
    nz_o   = 1'b0;
    ovf_o  = 1'b0;
    mag_s  = {1'b0, word_i[MAG_W-1:0]};
    neg_s  = '0;
    case (mode_i)
      MODE_SM2TC: begin
        if (word_i[MAG_W]) begin
          word_o = (~mag_s) + ONE;
          nz_o   = (mag_s == '0);
        end else begin
          word_o = mag_s;
        end
      end
      MODE_TC2SM: begin
        if (word_i[MAG_W]) begin
          neg_s = (~word_i) + ONE;
          if (neg_s[MAG_W]) begin
            word_o = {1'b1, {MAG_W{1'b1}}};
            ovf_o  = 1'b1;
          end else begin
            word_o = {1'b1, neg_s[MAG_W-1:0]};
          end
        end else begin
          word_o = word_i;
        end
      end
      default: begin
        word_o = '0;
      end
    endcase
  end
endmodule

// File: rtl/sm_tc_conv_pipe.sv
// Multi-lane SM<->TC converter with an elastic valid/ready pipeline of STAGES registers.
module sm_tc_conv_pipe
  import sm_tc_pkg::*;
#(
  parameter int unsigned MAG_W  = 13,
  parameter int unsigned LANES  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sm_tc_conv_pipe_if.slave   bus
);
  localparam int unsigned W  = lane_w(MAG_W);
  localparam int unsigned DW = bus_w(MAG_W, LANES);

  typedef struct packed {
    conv_mode_e       mode;
    logic [DW-1:0]    data;
    logic [LANES-1:0] nz;
    logic [LANES-1:0] ovf;
  } stage_t;

  conv_mode_e        mode_s;
  logic [DW-1:0]     conv_data_s;
  logic [LANES-1:0]  conv_nz_s;
  logic [LANES-1:0]  conv_ovf_s;
  stage_t            conv_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] v_q, v_d;
  stage_t [STAGES-1:0] pay_q, pay_d;

  assign mode_s = conv_mode_e'(bus.in_mode);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sm_tc_lane #(.MAG_W(MAG_W)) u_lane (
      .mode_i (mode_s),
      .word_i (bus.in_data[l*W +: W]),
      .word_o (conv_data_s[l*W +: W]),
      .nz_o   (conv_nz_s[l]),
      .ovf_o  (conv_ovf_s[l])
    );
  end

  assign conv_s = '{mode: mode_s, data: conv_data_s, nz: conv_nz_s, ovf: conv_ovf_s};

  // A stage may advance if it or any stage downstream of it has room, or the sink takes.
  always_comb begin
    logic run;
    run   = bus.out_ready;
    adv_s = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      run      = run || !v_q[k];
      adv_s[k] = run;
    end
  end

  // Next-state for valid bits and payloads; payloads only load when valid data arrives.
  always_comb begin
    v_d   = v_q;
    pay_d = pay_q;
    if (adv_s[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        pay_d[0] = conv_s;
      end else begin
        pay_d[0] = pay_q[0];
      end
    end else begin
      v_d[0] = v_q[0];
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (adv_s[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          pay_d[k] = pay_q[k-1];
        end else begin
          pay_d[k] = pay_q[k];
        end
      end else begin
        v_d[k] = v_q[k];
      end
    end
  end

  // Stage registers; reset drops every in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      pay_q <= '0;
    end else begin
      v_q   <= v_d;
      pay_q <= pay_d;
    end
  end

  assign bus.in_ready  = !rst && adv_s[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.out_data  = pay_q[STAGES-1].data;
  assign bus.out_nz    = pay_q[STAGES-1].nz;
  assign bus.out_ovf   = pay_q[STAGES-1].ovf;
endmodule

// File: tb/tb_sm_tc_conv_pipe.sv
// Randomised and directed bench for sm_tc_conv_pipe against an arithmetic reference model.
module tb_sm_tc_conv_pipe;
  localparam int MAG_W  = 13;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int W      = MAG_W + 1;
  localparam int DW     = LANES * W;

  typedef struct {
    logic [DW-1:0]    d;
    logic [LANES-1:0] nz;
    logic [LANES-1:0] ovf;
    int               cyc;
    int               stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  exp_t sb_q[$];
  exp_t got_q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [LANES-1:0] prev_nz, prev_ovf;

  sm_tc_conv_pipe_if #(.MAG_W(MAG_W), .LANES(LANES)) bus ();

  sm_tc_conv_pipe #(.MAG_W(MAG_W), .LANES(LANES), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value-level conversion with plain integer arithmetic.
  function automatic void ref_lane(input logic m, input logic [W-1:0] w,
                                   output logic [W-1:0] r, output logic nz, output logic ovf);
    int mag, x, a;
    nz = 1'b0; ovf = 1'b0;
    if (m == 1'b0) begin
      mag = int'(w[MAG_W-1:0]);
      x   = w[MAG_W] ? -mag : mag;
      r   = x[W-1:0];
      nz  = w[MAG_W] && (mag == 0);
    end else begin
      x = int'(w) - (w[MAG_W] ? (1 << W) : 0);
      if (x == -(1 << MAG_W)) begin
        r   = {1'b1, {MAG_W{1'b1}}};
        ovf = 1'b1;
      end else begin
        a = (x < 0) ? -x : x;
        r = {(x < 0), a[MAG_W-1:0]};
      end
    end
  endfunction

  function automatic exp_t ref_txn(input logic m, input logic [DW-1:0] d);
    exp_t e;
    logic [W-1:0] r;
    logic nz, ovf;
    e.d = '0; e.nz = '0; e.ovf = '0; e.cyc = 0; e.stl = 0;
    for (int l = 0; l < LANES; l++) begin
      ref_lane(m, d[l*W +: W], r, nz, ovf);
      e.d[l*W +: W] = r;
      e.nz[l]  = nz;
      e.ovf[l] = ovf;
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    logic [31:0]   u;
    for (int l = 0; l < LANES; l++) begin
      u = $urandom;
      case ($urandom_range(0, 5))
        0: d[l*W +: W] = '0;
        1: d[l*W +: W] = {1'b1, {MAG_W{1'b0}}};
        2: d[l*W +: W] = '1;
        3: d[l*W +: W] = {1'b0, {MAG_W{1'b1}}};
        default: d[l*W +: W] = u[W-1:0];
      endcase
    end
    return d;
  endfunction

  // Monitor: in_ready model, hold-while-stalled, scoreboard order and latency.
  always @(negedge clk) begin
    exp_t e, o;
    cyc++;
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (!bus.out_ready) stall_cnt++;
      check_eq("in_ready", bus.in_ready,
               !((sb_q.size() == STAGES) && !bus.out_ready));
      if (prev_stall) begin
        check_eq("hold_valid", bus.out_valid, 1'b1);
        check_eq("hold_data", bus.out_data, prev_data);
        check_eq("hold_flags", {bus.out_nz, bus.out_ovf}, {prev_nz, prev_ovf});
      end
      if (bus.out_valid && bus.out_ready) begin
        check_eq("sb_nonempty", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("out_data", bus.out_data, e.d);
          check_eq("out_nz", bus.out_nz, e.nz);
          check_eq("out_ovf", bus.out_ovf, e.ovf);
          if (e.stl == stall_cnt) check_eq("latency", cyc - e.cyc, STAGES);
        end
        o.d = bus.out_data; o.nz = bus.out_nz; o.ovf = bus.out_ovf; o.cyc = cyc; o.stl = 0;
        got_q.push_back(o);
      end
      if (bus.in_valid && bus.in_ready) begin
        e = ref_txn(bus.in_mode, bus.in_data);
        e.cyc = cyc;
        e.stl = stall_cnt;
        sb_q.push_back(e);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_nz    = bus.out_nz;
      prev_ovf   = bus.out_ovf;
    end
  end

  task automatic send(input logic m, input logic [DW-1:0] d);
    logic acc;
    int   t;
    bus.in_valid = 1'b1; bus.in_mode = m; bus.in_data = d;
    acc = 1'b0; t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = bus.in_ready && !rst;
      @(posedge clk); #1;
      t++;
    end
    check_eq("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  logic [DW-1:0] d;
  logic [DW-1:0] orig_q[$];
  logic [DW-1:0] mid_q[$];
  logic [DW-1:0] want;
  bit            rnd_done;

  initial begin
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) begin @(negedge clk); check_eq("rst_in_ready", bus.in_ready, 1'b0); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_data", bus.out_data, '0);
    check_eq("rst_out_flags", {bus.out_nz, bus.out_ovf}, '0);
    check_eq("rst_rel_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic SM->TC with latency.
    got_q.delete();
    d = '0; d[0 +: W] = 14'h2005; d[W +: W] = 14'h0005;
    send(1'b0, d); bus.in_valid = 1'b0; drain();
    check_eq("t1_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check_eq("t1_lane0", got_q[0].d[0 +: W], 14'h3FFB);
      check_eq("t1_lane1", got_q[0].d[W +: W], 14'h0005);
      check_eq("t1_flags", {got_q[0].nz, got_q[0].ovf}, '0);
    end

    // Negative zero and most-negative saturation.
    got_q.delete();
    d = '0; d[0 +: W] = 14'h2000;
    send(1'b0, d); send(1'b1, d); bus.in_valid = 1'b0; drain();
    check_eq("t2_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("t2_nz_word", got_q[0].d[0 +: W], 14'h0000);
      check_eq("t2_nz_flag", got_q[0].nz[0], 1'b1);
      check_eq("t2_ovf_word", got_q[1].d[0 +: W], 14'h3FFF);
      check_eq("t2_ovf_flag", got_q[1].ovf[0], 1'b1);
      check_eq("t2_ovf_nz", got_q[1].nz[0], 1'b0);
    end

    // TC->SM and round trip.
    got_q.delete();
    d = '0; d[0 +: W] = 14'h3FFB; d[W +: W] = 14'h1FFF;
    send(1'b1, d); bus.in_valid = 1'b0; drain();
    if (got_q.size() == 1) begin
      check_eq("t3_lane0", got_q[0].d[0 +: W], 14'h2005);
      check_eq("t3_lane1", got_q[0].d[W +: W], 14'h1FFF);
    end else begin
      check_eq("t3_count", got_q.size(), 1);
    end
    got_q.delete(); orig_q.delete(); mid_q.delete();
    for (int i = 0; i < 6; i++) begin
      d = rand_data(); orig_q.push_back(d); send(1'b0, d);
    end
    bus.in_valid = 1'b0; drain();
    foreach (got_q[i]) mid_q.push_back(got_q[i].d);
    got_q.delete();
    foreach (mid_q[i]) send(1'b1, mid_q[i]);
    bus.in_valid = 1'b0; drain();
    check_eq("rt_count", got_q.size(), orig_q.size());
    for (int i = 0; i < orig_q.size() && i < got_q.size(); i++) begin
      want = orig_q[i];
      for (int l = 0; l < LANES; l++)
        if (want[l*W +: W] == {1'b1, {MAG_W{1'b0}}}) want[l*W +: W] = '0;
      check_eq("roundtrip", got_q[i].d, want);
    end

    // Stream of 8 with a stall window.
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'($urandom_range(0, 1)), rand_data());
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 10; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("t4_count", got_q.size(), 8);

    // Mode alternates every cycle.
    for (int i = 0; i < 12; i++) send(1'(i % 2), rand_data());
    bus.in_valid = 1'b0; drain();

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(1'($urandom_range(0, 1)), rand_data());
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
        end
        bus.in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    send(1'b0, rand_data()); send(1'b1, rand_data());
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); check_eq("rst2_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst2_out_valid", bus.out_valid, 1'b0);
    check_eq("rst2_out_data", bus.out_data, '0);
    check_eq("rst2_flags", {bus.out_nz, bus.out_ovf}, '0);
    check_eq("rst2_in_ready_rel", bus.in_ready, 1'b1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (4) begin @(negedge clk); check_eq("rst2_no_output", bus.out_valid, 1'b0); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
